serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised bit-serial adder/subtractor built around a single full-adder cell that processes one operand bit per clock, LSB first. It replaces a WIDTH-bit parallel ripple adder where area matters more than latency. A START/DONE handshake controls it, and the last result is held stable between operations.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request a new operation; sampled only in IDLE or DONE_ST.
- SUB  in  1  0 = add, 1 = subtract; latched with START.
- A  in  WIDTH  first operand; latched with START.
- B  in  WIDTH  second operand; latched with START.
- Cin  in  1  carry-in (add) or borrow-in (subtract); latched with START.
- BUSY  out  1  high while bits are being processed.
- DONE  out  1  one-cycle pulse when SUM and Cout are valid.
- SUM  out  WIDTH  result register; holds the last result until the next DONE.
- Cout  out  1  raw carry out of the MSB.
- OVF  out  1  signed overflow; present only with the macro below.

## Operation
- States: IDLE, RUN, DONE_ST.
  - IDLE: START=1 → RUN.
  - RUN: after the bit counter reaches WIDTH-1 and that bit is processed → DONE_ST.
  - DONE_ST: START=1 → RUN; otherwise → IDLE.
- On the START edge:
  - Latch A and B into shift registers.
  - Latch SUB.
  - Initialise the carry flop to Cin XOR SUB.
  - Clear the bit counter.
- Each RUN cycle:
  - Let b = B[i] XOR SUB.
  - s = a ^ b ^ c; c' = (a & b) | (c & (a ^ b)).
  - Shift s into the MSB of the internal result shift register.
  - Shift the A and B registers right.
  - Increment the counter.
- Arithmetic:
  - Add: A + B + Cin.
  - Subtract: A + ~B + ~Cin, i.e. A − B − Cin in two's complement.
  - Subtract Cout = NOT borrow: 1 means no borrow.
- SUM, Cout and OVF are updated only on the edge that enters DONE_ST. They are unchanged during RUN.
- START in RUN is ignored; there is no queueing.
- A, B, SUB and Cin are don't-care outside the START edge.
- Reset, at any time including mid-RUN:
  - State → IDLE.
  - BUSY=0, DONE=0, SUM=0, Cout=0, OVF=0.
  - Internal registers cleared; any partial result is discarded.

## Timing
- START sampled high at edge k (IDLE or DONE_ST).
- BUSY=1 from edge k through edge k+WIDTH, i.e. WIDTH cycles.
- Bit i is computed at edge k+1+i.
- DONE=1 and the new SUM/Cout are visible from edge k+WIDTH for exactly one cycle.
- BUSY=0 whenever DONE=1.
- Latency is WIDTH cycles START→DONE.
- Back-to-back: START high during the DONE cycle is accepted, giving a throughput of one result per WIDTH+1 cycles.
- Throughput with START asserted only from IDLE is one result per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - OVF port exists.
  - At the DONE_ST edge, OVF = (carry into MSB) XOR (carry out of MSB).
  - OVF is held with SUM and reset to 0.
- Undefined:
  - OVF port and its flop are absent.
  - All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Add with wrap: A=8'hFF, B=8'h01, Cin=0, SUB=0. DONE is exactly 8 cycles after the START edge, with SUM=8'h00 and Cout=1. With the macro, OVF=0.
- Subtract: A=8'h05, B=8'h07, Cin=0, SUB=1 → SUM=8'hFE, Cout=0 (borrow). With the macro, OVF=0.
- Signed overflow (macro defined): A=8'h7F, B=8'h01, SUB=0 → SUM=8'h80, Cout=0, OVF=1. Without the macro, the same SUM and Cout result.
- START while BUSY:
  - Start 8'h10+8'h20, then pulse START with other operands at RUN cycle 3.
  - Required: a single DONE, SUM=8'h30.
  - SUM keeps its previous value until that DONE.
- Back-to-back: hold START high through the DONE cycle with new operands 8'h0A+8'h05+Cin=1. The second DONE arrives 9 cycles after the first, with SUM=8'h10 and Cout=0.
- Reset mid-operation:
  - Assert RST during RUN cycle 4.
  - All outputs are 0 immediately, with no DONE.
  - After release, a new 8'h01+8'h01 gives SUM=8'h02 in 8 cycles.

Source files
------------

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
// Purpose : operand/result bundle for the bit-serial adder/subtractor.
// Optional: SERIAL_ADDSUB_OVF_EN adds the signed-overflow flag OVF.
// Signals :
//   START  request a new operation (master -> slave)
//   SUB    0 = add, 1 = subtract (master -> slave)
//   A, B   operands, WIDTH bits (master -> slave)
//   Cin    carry-in / borrow-in (master -> slave)
//   BUSY   bits being processed (slave -> master)
//   DONE   one-cycle result-valid pulse (slave -> master)
//   SUM    held result, WIDTH bits (slave -> master)
//   Cout   raw carry out of the MSB (slave -> master)
//   OVF    signed overflow, macro builds only (slave -> master)
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             OVF;
`endif

`ifdef SERIAL_ADDSUB_OVF_EN
    modport master (
        output START, SUB, A, B, Cin,
        input  BUSY, DONE, SUM, Cout, OVF
    );

    modport slave (
        input  START, SUB, A, B, Cin,
        output BUSY, DONE, SUM, Cout, OVF
    );
`else
    modport master (
        output START, SUB, A, B, Cin,
        input  BUSY, DONE, SUM, Cout
    );

    modport slave (
        input  START, SUB, A, B, Cin,
        output BUSY, DONE, SUM, Cout
    );
`endif
endinterface

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Purpose : bit-serial adder/subtractor. One full-adder cell processes one
//           operand bit per clock, LSB first; a WIDTH-bit result is ready
//           WIDTH cycles after START and held until the next completion.
// Optional: define SERIAL_ADDSUB_OVF_EN to add the signed-overflow flag OVF.
// Ports   :
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset
//   bus    serial_addsub_if.slave (START/SUB/A/B/Cin in,
//          BUSY/DONE/SUM/Cout[/OVF] out, all outputs registered)
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    serial_addsub_if.slave        bus
);

    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Full-adder cell on the current LSBs; B is inverted for subtraction.
    logic bit_a;
    logic bit_b;
    logic bit_s;
    logic bit_c;

    always_comb begin
        bit_a = a_q[0];
        bit_b = b_q[0] ^ sub_q;
        bit_s = bit_a ^ bit_b ^ carry_q;
        bit_c = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE, DONE_ST: begin
                if (bus.START) begin
                    // Subtraction is A + ~B + ~Cin, so the carry seeds as Cin^SUB.
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sub_d   = bus.SUB;
                    carry_d = bus.Cin ^ bus.SUB;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = bit_c;
                if (cnt_q == LAST_BIT) begin
                    // MSB processed: publish result; carry_q is the carry into the MSB.
                    state_d = DONE_ST;
                    done_d  = 1'b1;
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = bit_c;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = carry_q ^ bit_c;
`endif
                end else begin
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.SUM  = sum_q;
    assign bus.Cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign bus.OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
// Purpose : directed scoreboard bench for serial_addsub at WIDTH = 8.
//           Stimulus pushes hand-computed results; a monitor pops on DONE.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && bus.DONE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected DONE", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " SUM"},  32'(bus.SUM),  32'(mon_e.sum));
                check({mon_e.name, " Cout"}, 32'(bus.Cout), 32'(mon_e.cout));
`ifdef SERIAL_ADDSUB_OVF_EN
                check({mon_e.name, " OVF"},  32'(bus.OVF),  32'(mon_e.ovf));
`endif
                check({mon_e.name, " latency"}, 32'(cyc), 32'(mon_e.done_cyc));
                check({mon_e.name, " BUSY at DONE"}, 32'(bus.BUSY), 32'd0);
            end
        end
    end

    // Called at a negedge: pulses START for one edge, returns the edge index k.
    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                         input bit push, output int k);
        exp_t e;
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        bus.SUB   = sub;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        k = cyc;
        bus.START = 1'b0;
        if (push) begin
            e.name     = name;
            e.sum      = exp_sum;
            e.cout     = exp_cout;
            e.ovf      = exp_ovf;
            e.done_cyc = k + int'(W);
            sb.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic wait_cyc(input int target);
        for (int t = 0; t < 40 && cyc != target; t++) @(negedge CLK);
        if (cyc != target) check("wait cycle timeout", 32'(cyc), 32'(target));
    endtask

    // Waits for outstanding results, then idles long enough to expose stray DONEs.
    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge CLK);
        if (sb.size() != 0) begin
            check("DONE timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (12) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " BUSY"}, 32'(bus.BUSY), 32'd0);
        check({name, " DONE"}, 32'(bus.DONE), 32'd0);
        check({name, " SUM"},  32'(bus.SUM),  32'd0);
        check({name, " Cout"}, 32'(bus.Cout), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check({name, " OVF"},  32'(bus.OVF),  32'd0);
`endif
    endtask

    initial begin
        int k;
        int k1;
        bus.START = 1'b0;
        bus.SUB   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        RST       = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        issue("add wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, k);
        drain();
        issue("sub borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, k);
        drain();
        issue("signed ovf add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, k);
        drain();

        // START during RUN is ignored; SUM holds 8'h80 until the single DONE.
        issue("start while busy", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, k);
        wait_cyc(k + 3);
        check("SUM held in RUN", 32'(bus.SUM), 32'h80);
        check("BUSY in RUN", 32'(bus.BUSY), 32'd1);
        issue("ignored", 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, k1);
        wait_cyc(k + 6);
        check("SUM held late RUN", 32'(bus.SUM), 32'h80);
        drain();

        issue("sub with borrow-in", 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, k);
        drain();
        issue("signed ovf sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, k);
        drain();

        // Back-to-back: second START during the DONE cycle; second DONE 9 cycles later.
        issue("b2b first", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, k);
        wait_cyc(k + int'(W));
        check("DONE before b2b start", 32'(bus.DONE), 32'd1);
        issue("b2b second", 8'h0A, 8'h05, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, k1);
        check("b2b start edge", 32'(k1), 32'(k + int'(W) + 1));
        drain();

        // Reset mid-RUN discards the operation and clears all outputs at once.
        issue("aborted", 8'h55, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, k);
        wait_cyc(k + 4);
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("mid-run reset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check("no DONE after reset", 32'(bus.DONE), 32'd0);
        issue("after reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, k);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
